// File: rtl/uart_param_if.sv
// Client-side bundle of the UART: baud/frame configuration plus both valid/ready handshakes.
// The client drives through the master modport and the UART core sits on the slave modport.
interface uart_param_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BAUD_W    = 24
);
  logic [BAUD_W-1:0]    baud;
  logic [1:0]           parity_mode;
  logic                 two_stop;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 overrun_clr;

  modport master (
    output baud, parity_mode, two_stop, tx_data, tx_valid, rx_ready, overrun_clr,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  baud, parity_mode, two_stop, tx_data, tx_valid, rx_ready, overrun_clr,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_param.sv
// Full-duplex UART with a runtime baud rate from a fractional tick accumulator,
// configurable parity/stop bits and a 16x-oversampled receiver with error reporting.
module uart_param #(
  parameter int unsigned SYS_CLK_RATE = 50000000,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned BAUD_W       = 24
) (
  input  logic         clk,
  input  logic         rst,
  uart_param_if.slave  bus,
  output logic         tx,
  input  logic         rx
);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [31:0]      CLK_RATE = 32'(SYS_CLK_RATE);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP_OR_PAR} rx_state_t;

  // Shared oversample tick: accumulate OVERSAMPLE*baud, wrap at the system clock rate
  logic [31:0] acc, acc_n;
  logic        tick;

  always_comb acc_n = acc + (32'(OVERSAMPLE) * 32'(bus.baud[BAUD_W-1:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_n >= CLK_RATE) begin
      acc  <= acc_n - CLK_RATE;
      tick <= 1'b1;
    end else begin
      acc  <= acc_n;
      tick <= 1'b0;
    end
  end

  // Transmitter; tx_arm holds the line idle until the first tick after accept
  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par_en, tx_par_bit, tx_two, tx_arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_sh        <= '0;
      tx_par_en    <= 1'b0;
      tx_par_bit   <= 1'b0;
      tx_two       <= 1'b0;
      tx_arm       <= 1'b0;
      tx           <= 1'b1;
      bus.tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_valid && bus.tx_ready) begin
            tx_sh        <= bus.tx_data;
            tx_par_en    <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
            tx_par_bit   <= (^bus.tx_data) ^ bus.parity_mode[1];
            tx_two       <= bus.two_stop;
            tx_arm       <= 1'b1;
            bus.tx_ready <= 1'b0;
            tx_state     <= TX_START;
          end
        end
        default: begin
          if (tick) begin
            if (tx_arm) begin
              tx_arm <= 1'b0;
              tx     <= 1'b0;
              tx_cnt <= '0;
            end else if (tx_cnt != CNT_LAST) begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end else begin
              tx_cnt <= '0;
              case (tx_state)
                TX_START: begin
                  tx       <= tx_sh[0];
                  tx_sh    <= tx_sh >> 1;
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
                end
                TX_DATA: begin
                  if (tx_bit == BIT_LAST) begin
                    tx       <= tx_par_en ? tx_par_bit : 1'b1;
                    tx_state <= tx_par_en ? TX_PARITY : TX_STOP1;
                  end else begin
                    tx     <= tx_sh[0];
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + BIT_W'(1);
                  end
                end
                TX_PARITY: begin
                  tx       <= 1'b1;
                  tx_state <= TX_STOP1;
                end
                TX_STOP1: begin
                  if (tx_two) begin
                    tx_state <= TX_STOP2;
                  end else begin
                    tx_state     <= TX_IDLE;
                    bus.tx_ready <= 1'b1;
                  end
                end
                default: begin
                  tx_state     <= TX_IDLE;
                  bus.tx_ready <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // Receiver input synchroniser and edge history
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_par_en, rx_odd, rx_perr, rx_in_par, rx_take;

  // Half a bit into the start bit, then once per bit
  always_comb begin
    rx_take = 1'b0;
    if (tick) rx_take = (rx_state == RX_START) ? (rx_cnt == CNT_HALF) : (rx_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state          <= RX_IDLE;
      rx_cnt            <= '0;
      rx_bit            <= '0;
      rx_sh             <= '0;
      rx_par_en         <= 1'b0;
      rx_odd            <= 1'b0;
      rx_perr           <= 1'b0;
      rx_in_par         <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_valid      <= 1'b0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
      bus.rx_overrun    <= 1'b0;
    end else begin
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
      if (bus.overrun_clr) bus.rx_overrun <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state  <= RX_START;
            rx_cnt    <= '0;
            rx_perr   <= 1'b0;
            rx_par_en <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
            rx_odd    <= bus.parity_mode[1];
          end
        end
        default: begin
          if (tick && !rx_take) begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end else if (rx_take) begin
            rx_cnt <= '0;
            case (rx_state)
              RX_START: begin
                rx_bit   <= '0;
                rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
              end
              RX_DATA: begin
                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_bit == BIT_LAST) begin
                  rx_in_par <= rx_par_en;
                  rx_state  <= RX_STOP_OR_PAR;
                end else begin
                  rx_bit <= rx_bit + BIT_W'(1);
                end
              end
              default: begin
                if (rx_in_par) begin
                  rx_perr   <= rx_s2 ^ (^rx_sh) ^ rx_odd;
                  rx_in_par <= 1'b0;
                end else begin
                  // Stop sample: deliver the word, overwriting an unread one
                  bus.rx_data       <= rx_sh;
                  bus.rx_parity_err <= rx_perr;
                  bus.rx_frame_err  <= !rx_s2;
                  bus.rx_valid      <= 1'b1;
                  if (bus.rx_valid && !bus.rx_ready) bus.rx_overrun <= 1'b1;
                  rx_state <= RX_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: 8-bit instance driven/observed directly, 7-bit instance in tx->rx loopback.
module tb_uart_param;
  localparam int BIT8 = 434;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx8, rx8, tx7;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs7 = 0;
  rx_exp_t    q8[$];
  rx_exp_t    q7[$];
  logic [7:0] txq[$];

  uart_param_if #(.DATA_BITS(8), .BAUD_W(24)) bus8 ();
  uart_param_if #(.DATA_BITS(7), .BAUD_W(24)) bus7 ();

  uart_param #(.SYS_CLK_RATE(50000000), .DATA_BITS(8), .OVERSAMPLE(16), .BAUD_W(24)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .tx(tx8), .rx(rx8));

  uart_param #(.SYS_CLK_RATE(2000000), .DATA_BITS(7), .OVERSAMPLE(16), .BAUD_W(24)) dut7 (
    .clk(clk), .rst(rst), .bus(bus7), .tx(tx7), .rx(tx7));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops the scoreboard on every rx handshake of the 8-bit instance
  task automatic mon8();
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (bus8.rx_valid && bus8.rx_ready) begin
        if (q8.size() == 0) check("rx8_unexpected", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          check("rx8_data", 32'(bus8.rx_data), 32'(e.data));
          check("rx8_perr", 32'(bus8.rx_parity_err), 32'(e.perr));
          check("rx8_ferr", 32'(bus8.rx_frame_err), 32'(e.ferr));
        end
      end
    end
  endtask

  task automatic mon7();
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (bus7.rx_valid && bus7.rx_ready) begin
        hs7++;
        if (q7.size() == 0) check("lb_unexpected", 32'd1, 32'd0);
        else begin
          e = q7.pop_front();
          check("lb_data", 32'(bus7.rx_data), 32'(e.data));
          check("lb_perr", 32'(bus7.rx_parity_err), 32'(e.perr));
          check("lb_ferr", 32'(bus7.rx_frame_err), 32'(e.ferr));
        end
      end
    end
  endtask

  task automatic tx8_send(input logic [7:0] d, input bit push);
    logic rdy;
    int   n;
    bus8.tx_data  = d;
    bus8.tx_valid = 1'b1;
    n = 0;
    do begin
      rdy = bus8.tx_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 20000);
    bus8.tx_valid = 1'b0;
    check("tx8_accept", 32'(rdy), 32'd1);
    if (push) txq.push_back(d);
  endtask

  task automatic tx7_send(input logic [6:0] d);
    logic rdy;
    int   n;
    bus7.tx_data  = d;
    bus7.tx_valid = 1'b1;
    n = 0;
    do begin
      rdy = bus7.tx_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 20000);
    bus7.tx_valid = 1'b0;
    check("tx7_accept", 32'(rdy), 32'd1);
    q7.push_back('{data: 9'(d), perr: 1'b0, ferr: 1'b0});
  endtask

  // Decodes one 8N1 frame on tx8 and compares it with the scoreboard
  task automatic tx8_check();
    int n, t0, len;
    logic [7:0] got, exp;
    n = 0;
    while (tx8 !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check("tx_start_seen", 32'(n < 20000), 32'd1);
    t0 = cyc;
    wait_cycles(BIT8 / 2);
    check("tx_start_bit", 32'(tx8), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_cycles(BIT8);
      got[i] = tx8;
    end
    wait_cycles(BIT8);
    check("tx_stop_bit", 32'(tx8), 32'd1);
    n = 0;
    while (bus8.tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    len = cyc - t0;
    check("tx_frame_len", 32'((len >= 10 * BIT8 - 27) && (len <= 10 * BIT8 + 28)), 32'd1);
    if (txq.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
    else begin
      exp = txq.pop_front();
      check("tx_data", 32'(got), 32'(exp));
    end
  endtask

  task automatic rx8_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                           input logic stop);
    rx8 = 1'b0;
    wait_cycles(BIT8);
    for (int i = 0; i < 8; i++) begin
      rx8 = d[i];
      wait_cycles(BIT8);
    end
    if (par_en) begin
      rx8 = par_bit;
      wait_cycles(BIT8);
    end
    rx8 = stop;
    wait_cycles(BIT8);
    rx8 = 1'b1;
    wait_cycles(BIT8);
  endtask

  initial begin
    int n;
    rx8 = 1'b1;
    bus8.baud = 24'd115200;  bus8.parity_mode = 2'b00; bus8.two_stop = 1'b0;
    bus8.tx_data = '0; bus8.tx_valid = 1'b0; bus8.rx_ready = 1'b1; bus8.overrun_clr = 1'b0;
    bus7.baud = 24'd9600;    bus7.parity_mode = 2'b01; bus7.two_stop = 1'b1;
    bus7.tx_data = '0; bus7.tx_valid = 1'b0; bus7.rx_ready = 1'b1; bus7.overrun_clr = 1'b0;
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(2);

    check("rst_tx", 32'(tx8), 32'd1);
    check("rst_tx_ready", 32'(bus8.tx_ready), 32'd1);
    check("rst_rx_valid", 32'(bus8.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus8.rx_data), 32'd0);
    check("rst_flags", 32'({bus8.rx_parity_err, bus8.rx_frame_err, bus8.rx_overrun}), 32'd0);
    check("rst_tx7", 32'(tx7), 32'd1);

    fork
      mon8();
      mon7();
    join_none

    // 8N1 transmit of 0xA5
    tx8_send(8'hA5, 1'b1);
    tx8_check();

    // 7E2 loopback, three words back to back
    tx7_send(7'h00);
    tx7_send(7'h55);
    tx7_send(7'h7F);
    n = 0;
    while (hs7 < 3 && n < 15000) begin @(negedge clk); n++; end
    check("lb_handshakes", 32'(hs7), 32'd3);

    // Odd parity configured, even parity bit sent
    bus8.parity_mode = 2'b10;
    q8.push_back('{data: 9'h03C, perr: 1'b1, ferr: 1'b0});
    rx8_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    bus8.parity_mode = 2'b00;

    // Stop bit held low
    q8.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b1});
    rx8_frame(8'h5A, 1'b0, 1'b0, 1'b0);

    // Quarter-bit glitch, then a good frame
    rx8 = 1'b0;
    wait_cycles(BIT8 / 4);
    rx8 = 1'b1;
    wait_cycles(2 * BIT8);
    check("glitch_no_valid", 32'(bus8.rx_valid), 32'd0);
    q8.push_back('{data: 9'h081, perr: 1'b0, ferr: 1'b0});
    rx8_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check("rx8_q_drained", 32'(q8.size()), 32'd0);

    // Overrun: two words with rx_ready low
    @(posedge clk); #1 bus8.rx_ready = 1'b0;
    rx8_frame(8'h11, 1'b0, 1'b0, 1'b1);
    q8.push_back('{data: 9'h022, perr: 1'b0, ferr: 1'b0});
    rx8_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_valid", 32'(bus8.rx_valid), 32'd1);
    check("ovr_data", 32'(bus8.rx_data), 32'h22);
    check("ovr_flag", 32'(bus8.rx_overrun), 32'd1);
    @(posedge clk); #1 bus8.rx_ready = 1'b1;
    wait_cycles(3);
    check("ovr_sticky", 32'(bus8.rx_overrun), 32'd1);
    bus8.overrun_clr = 1'b1;
    wait_cycles(1);
    bus8.overrun_clr = 1'b0;
    wait_cycles(1);
    check("ovr_cleared", 32'(bus8.rx_overrun), 32'd0);

    // Reset in the middle of data bit 3
    tx8_send(8'hA5, 1'b0);
    n = 0;
    while (tx8 !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check("rst_mid_start_seen", 32'(n < 20000), 32'd1);
    wait_cycles(4 * BIT8 + BIT8 / 2);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx8), 32'd1);
    check("rst_mid_tx_ready", 32'(bus8.tx_ready), 32'd1);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    tx8_send(8'h0F, 1'b1);
    tx8_check();

    check("txq_drained", 32'(txq.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q7_drained", 32'(q7.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART with a runtime-programmable baud rate.
- Configurable data width, parity mode and stop-bit count.
- 16x-oversampled receiver with mid-bit sampling and false-start rejection.
- Parity, framing and overrun error reporting.
- Valid/ready handshakes on both the transmit and receive sides; sits between a byte-stream client and the board serial pins.

Parameters:
SYS_CLK_RATE  50000000  system clock frequency in Hz
DATA_BITS  8  data bits per frame, legal 5..9
OVERSAMPLE  16  baud ticks per bit, power of two, >=8
BAUD_W  24  width of the baud input

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
baud  in  BAUD_W  baud rate in Hz; 0 = generator halted
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
two_stop  in  1  1 = two stop bits, 0 = one
tx_data  in  DATA_BITS  byte to send
tx_valid  in  1  client offers tx_data
tx_ready  out  1  transmitter idle; transfer occurs when tx_valid & tx_ready
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data holds an unread word
rx_ready  in  1  client consumes rx_data
rx_parity_err  out  1  parity error flag for the current rx_data
rx_frame_err  out  1  first stop bit sampled low for the current rx_data
rx_overrun  out  1  sticky; set when a frame completes while rx_valid=1
overrun_clr  in  1  clears rx_overrun

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, both FSMs IDLE, accumulator 0.
- Tick generator:
  - 32-bit accumulator; each clk, acc_n = acc + OVERSAMPLE*baud.
  - If acc_n >= SYS_CLK_RATE: acc <= acc_n - SYS_CLK_RATE and tick=1 for one cycle; else acc <= acc_n.
  - baud=0 gives no ticks; FSMs freeze in their current state.
  - Legal only while OVERSAMPLE*baud < SYS_CLK_RATE.
  - One shared generator serves TX and RX; RX phase comes from its own tick counter.
- Config latch: parity_mode and two_stop are latched at TX accept and at RX start detect. Mid-frame changes do not affect the frame in progress.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when no parity) -> STOP1 -> STOP2 (only when two_stop) -> IDLE.
  - Each non-IDLE state lasts exactly OVERSAMPLE ticks.
  - Accept tx_data on the clk where tx_valid & tx_ready. tx_ready drops the next cycle. tx goes low on the first tick after accept.
  - Data is sent LSB first.
  - Parity bit = XOR of data (even) or its inverse (odd).
  - tx_ready returns high the cycle after the last stop bit ends. A new word offered then starts with no extra idle bit.
- RX input path:
  - rx passes through a 2-flop synchroniser.
  - The IDLE falling edge (sync 1 -> 0) starts the frame and clears the tick counter.
- RX FSM: IDLE -> START -> DATA -> PARITY? -> STOP -> IDLE.
  - START: at tick OVERSAMPLE/2, if sync rx=1 it is a false start; return to IDLE with no output. Otherwise sample every OVERSAMPLE ticks thereafter.
  - STOP samples only the first stop bit; a second stop bit is treated as idle.
  - On the STOP sample (the same cycle), load rx_data and set rx_valid=1.
  - rx_parity_err and rx_frame_err are loaded with the word and are valid while rx_valid=1.
  - The FSM returns to IDLE immediately after the STOP sample, so a start bit may follow at half a bit.
- RX handshake and overrun:
  - rx_valid clears the cycle after rx_valid & rx_ready.
  - If a new word completes while rx_valid=1 and rx_ready=0, the new word and flags overwrite the old, rx_valid stays 1, and rx_overrun is set.
  - If rx_ready=1 on that same cycle, the old word is consumed, the new one is loaded, and there is no overrun.
  - rx_overrun clears only on overrun_clr or rst. When set and clear coincide, set wins.
- Reset mid-frame: both sides abort. tx returns high asynchronously; a partial RX word is discarded.

Test Plan:
- Transmit: SYS_CLK=50MHz, baud=115200, 8N1, send 0xA5 -> tx low 1 bit, then bits 1,0,1,0,0,1,0,1, then high. Frame is 10 bit-times ±1 tick; tx_ready returns high.
- Loopback tx->rx: 7 data bits, even parity, two stop bits, 9600 baud, words 0x00, 0x55, 0x7F back-to-back -> identical rx_data, errors 0, three rx_valid handshakes.
- Parity error: drive rx frame 0x3C with odd parity configured but an even parity bit -> rx_valid=1, rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
- Framing and false start: stop bit driven low -> rx_frame_err=1. Separately, a 0.25-bit low glitch -> no rx_valid, and a following valid frame 0x81 is received correctly.
- Overrun: hold rx_ready=0 and receive 0x11 then 0x22 -> rx_data=0x22, rx_overrun=1. Then overrun_clr -> rx_overrun=0.
- Reset mid-frame: assert rst during TX data bit 3 -> tx=1 and tx_ready=1 immediately. After release, send 0x0F -> frame is correct.
